// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the 5-stage pipeline hazard logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: hz_state encoding (HZ_RUN/HZ_MEM_WAIT/HZ_ERR), default register
// specifier width, and the register index that holds the PC.
package pipe_pkg;

  localparam int REG_W_DEF = 4;

  // Writes to this register are redirects, not data, so they never create a
  // load-use dependency.
  localparam int PC_REG = 15;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_ERR      = 2'b10
  } hz_state_e;

endpackage

// File: rtl/lu_detect.sv
// lu_detect: load-use hazard comparator between the EX load and the ID reader.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only reports the hazard, the caller decides to stall.
// Ports: ex_load/ex_rf_we/ex_rd describe the EX instruction; id_rn/id_rm/id_rd
// with their id_use_* qualifiers describe the ID reads; lu is the hazard flag.
module lu_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_load,
  input  logic             ex_rf_we,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  output logic             lu
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic src_match;

  assign src_match = (id_use_rn && (id_rn == ex_rd)) ||
                     (id_use_rm && (id_rm == ex_rd)) ||
                     (id_use_rd && (id_rd == ex_rd));

  assign lu = ex_load && ex_rf_we && (ex_rd != PC_IDX) && src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the IF/ID/EX/MEM/WB pipe.
// Latency: enables/clears are combinational, same cycle as the triggering inputs.
// Backpressure: a pending data-memory access freezes every stage; load-use
// freezes PC and IF/ID for one cycle; a MEM wait that is too long locks in ERR.
// Ports: clk/reset_n (async active-low); ID specifiers and use flags; ID taken
// branch; EX destination/load/write flags; mem_req/mem_ready from MEM;
// *_en register loads, *_clr bubble inserts, hz_state, sticky mem_err.
// Optional feature macro HZ_PERF_CNT_EN adds saturating perf_stall/perf_flush.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_W       = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_branch_taken,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load,
  input  logic             ex_rf_we,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             mem_wb_clr,
  output logic [1:0]       hz_state,
  output logic             mem_err
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [15:0]      perf_stall,
  output logic [15:0]      perf_flush
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  hz_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       err_q, err_d;
  logic       lu;
  logic       frozen;   // whole pipe held for a memory access this cycle
  logic       run_sel;  // memory satisfied: LU/branch rules apply
  logic [4:0] en_v;     // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [2:0] clr_v;    // {if_id, id_ex, mem_wb}

  lu_detect #(.REG_W(REG_W)) u_lu (
    .ex_load   (ex_load),
    .ex_rf_we  (ex_rf_we),
    .ex_rd     (ex_rd),
    .id_rn     (id_rn),
    .id_rm     (id_rm),
    .id_rd     (id_rd),
    .id_use_rn (id_use_rn),
    .id_use_rm (id_use_rm),
    .id_use_rd (id_use_rd),
    .lu        (lu)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    frozen  = 1'b0;
    run_sel = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (mem_req && !mem_ready) begin
          frozen  = 1'b1;
          state_d = HZ_MEM_WAIT;
          cnt_d   = '0;
        end else begin
          run_sel = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        // Only mem_ready matters here: the access is already committed.
        if (!mem_ready) begin
          frozen = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            state_d = HZ_ERR;
            err_d   = 1'b1;
          end
        end else begin
          run_sel = 1'b1;
          state_d = HZ_RUN;
        end
      end
      HZ_ERR: begin
        state_d = HZ_ERR;
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase

    // Default is the fully-held, fully-bubbled pattern used by reset and ERR.
    en_v  = 5'b00000;
    clr_v = 3'b111;
    if (!reset_n) begin
      en_v  = 5'b00000;
      clr_v = 3'b111;
    end else if (frozen) begin
      // WB still retires, so only MEM/WB is bubbled behind the frozen access.
      en_v  = 5'b00000;
      clr_v = 3'b001;
    end else if (run_sel) begin
      if (lu) begin
        // A branch in ID is dropped here; it is re-evaluated next cycle.
        en_v  = 5'b00111;
        clr_v = 3'b010;
      end else if (id_branch_taken) begin
        en_v  = 5'b11111;
        clr_v = 3'b100;
      end else begin
        en_v  = 5'b11111;
        clr_v = 3'b000;
      end
    end
  end

  assign pc_en      = en_v[4];
  assign if_id_en   = en_v[3];
  assign id_ex_en   = en_v[2];
  assign ex_mem_en  = en_v[1];
  assign mem_wb_en  = en_v[0];
  assign if_id_clr  = clr_v[2];
  assign id_ex_clr  = clr_v[1];
  assign mem_wb_clr = clr_v[0];
  assign hz_state   = state_q;
  assign mem_err    = err_q;

`ifdef HZ_PERF_CNT_EN
  logic stall_ev, flush_ev;

  assign stall_ev = frozen || (run_sel && lu);
  assign flush_ev = run_sel && !lu && id_branch_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall_ev && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
      if (flush_ev && (perf_flush != 16'hFFFF)) perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] id_rn, id_rm, id_rd, ex_rd;
  logic       id_use_rn, id_use_rm, id_use_rd, id_branch_taken;
  logic       ex_load, ex_rf_we, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_clr, id_ex_clr, mem_wb_clr;
  logic [1:0] hz_state;
  logic       mem_err;
`ifdef HZ_PERF_CNT_EN
  logic [15:0] perf_stall, perf_flush;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .REG_W(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_rd           (id_rd),
    .id_use_rn       (id_use_rn),
    .id_use_rm       (id_use_rm),
    .id_use_rd       (id_use_rd),
    .id_branch_taken (id_branch_taken),
    .ex_rd           (ex_rd),
    .ex_load         (ex_load),
    .ex_rf_we        (ex_rf_we),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_clr       (if_id_clr),
    .id_ex_clr       (id_ex_clr),
    .mem_wb_clr      (mem_wb_clr),
    .hz_state        (hz_state),
    .mem_err         (mem_err)
`ifdef HZ_PERF_CNT_EN
    ,
    .perf_stall      (perf_stall),
    .perf_flush      (perf_flush)
`endif
  );

  typedef struct packed {
    logic [4:0]  en;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [2:0]  clr;  // if_id, id_ex, mem_wb
    logic [1:0]  hz;
    logic        err;
    logic [15:0] ps;
    logic [15:0] pf;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference model: pipeline mode, cycles spent waiting, sticky error, perf counts.
  int m_mode   = 0;  // 0 running, 1 waiting on memory, 2 error
  int m_waited = 0;
  bit m_err    = 0;
  int m_ps     = 0;
  int m_pf     = 0;

  task automatic cyc();
    obs_t e;
    bit   lu, blocked;
    e  = '0;
    lu = ex_load && ex_rf_we && (ex_rd != 4'd15) &&
         ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd) ||
          (id_use_rd && id_rd == ex_rd));
    if (!reset_n) begin
      e.en = 5'b00000; e.clr = 3'b111; e.hz = 2'b00; e.err = 1'b0;
      m_mode = 0; m_waited = 0; m_err = 0; m_ps = 0; m_pf = 0;
    end else begin
      e.hz  = m_mode[1:0];
      e.err = m_err;
      e.ps  = m_ps[15:0];
      e.pf  = m_pf[15:0];
      if (m_mode == 2) begin
        e.en = 5'b00000; e.clr = 3'b111;
      end else begin
        blocked = (m_mode == 0) ? (mem_req && !mem_ready) : !mem_ready;
        if (blocked) begin
          e.en = 5'b00000; e.clr = 3'b001;
          if (m_ps < 65535) m_ps++;
          if (m_mode == 0) begin
            m_mode = 1; m_waited = 0;
          end else begin
            m_waited++;
            if (m_waited == TO) begin m_mode = 2; m_err = 1; end
          end
        end else begin
          m_mode = 0;
          if (lu) begin
            e.en = 5'b00111; e.clr = 3'b010;
            if (m_ps < 65535) m_ps++;
          end else if (id_branch_taken) begin
            e.en = 5'b11111; e.clr = 3'b100;
            if (m_pf < 65535) m_pf++;
          end else begin
            e.en = 5'b11111; e.clr = 3'b000;
          end
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.en  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
      a.clr = {if_id_clr, id_ex_clr, mem_wb_clr};
      a.hz  = hz_state;
      a.err = mem_err;
`ifdef HZ_PERF_CNT_EN
      a.ps = perf_stall;
      a.pf = perf_flush;
`else
      a.ps = '0; a.pf = '0;
      e.ps = '0; e.pf = '0;
`endif
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d actual en=%b clr=%b hz=%b err=%b ps=%0d pf=%0d required en=%b clr=%b hz=%b err=%b ps=%0d pf=%0d",
                 cyc_n, a.en, a.clr, a.hz, a.err, a.ps, a.pf, e.en, e.clr, e.hz, e.err, e.ps, e.pf);
      end
      cyc_n++;
    end
  end

  task automatic idle();
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; ex_rd = 4'd0;
    id_use_rn = 0; id_use_rm = 0; id_use_rd = 0; id_branch_taken = 0;
    ex_load = 0; ex_rf_we = 0; mem_req = 0; mem_ready = 0;
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    reset_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Load-use on Rn, then the load has moved on.
    ex_load = 1; ex_rf_we = 1; ex_rd = 4'd3; id_use_rn = 1; id_rn = 4'd3;
    cyc();
    ex_load = 0;
    cyc();

    // Load-use hides a taken branch; branch acts the following cycle.
    ex_load = 1; id_branch_taken = 1;
    cyc();
    ex_load = 0;
    cyc();
    idle();
    cyc();

    // Load writing the PC is never a hazard.
    ex_load = 1; ex_rf_we = 1; ex_rd = 4'd15; id_use_rm = 1; id_rm = 4'd15;
    cyc();
    idle();

    // Memory ready in the same cycle as the request: no stall.
    mem_req = 1; mem_ready = 1;
    cyc();

    // Three-cycle memory wait.
    mem_ready = 0;
    repeat (3) cyc();
    mem_ready = 1;
    cyc();
    idle();
    cyc();

    // Timeout into ERR, held there until reset.
    mem_req = 1; mem_ready = 0;
    repeat (8) cyc();
    mem_ready = 1;
    cyc();
    reset_n = 0;
    cyc();
    reset_n = 1;
    idle();
    cyc();

    // Reset in the middle of a wait.
    mem_req = 1; mem_ready = 0;
    repeat (2) cyc();
    reset_n = 0;
    cyc();
    reset_n = 1;
    idle();
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n         = ($urandom_range(0, 99) != 0);
      id_rn           = rreg();
      id_rm           = rreg();
      id_rd           = rreg();
      ex_rd           = rreg();
      id_use_rn       = $urandom_range(0, 1);
      id_use_rm       = $urandom_range(0, 1);
      id_use_rd       = ($urandom_range(0, 3) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      ex_load         = $urandom_range(0, 1);
      ex_rf_we        = ($urandom_range(0, 3) != 0);
      mem_req         = ($urandom_range(0, 4) == 0);
      mem_ready       = (m_mode == 1) ? ($urandom_range(0, 9) < 3) : $urandom_range(0, 1);
      cyc();
    end

    idle();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
